// File: rtl/redip_pkg.sv
// Shared types and constants for the warm-boot request path.
package redip_pkg;

    typedef enum logic [2:0] {
        WB_IDLE,
        WB_GOT_R,
        WB_GOT_B,
        WB_ARM,
        WB_BOOT
    } warmboot_state_t;

    localparam logic [7:0] WB_MAGIC_R = 8'h52;
    localparam logic [7:0] WB_MAGIC_B = 8'h42;

    function automatic int wb_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/warmboot_ctrl.sv
// Watches register writes for the 'R','B',image unlock sequence and then
// issues a delayed, sticky warm-boot request with a frozen image select.
module warmboot_ctrl
    import redip_pkg::*;
#(
    parameter logic [4:0] MAGIC_ADDR = 5'h1F,
    parameter int         TIMEOUT    = 24_000,
    parameter int         ARM_DELAY  = 240     // must be >= 1
) (
    input  logic       clk_24,
    input  logic       rst_24_n,
    input  logic       enable,
    input  logic       bus_we,
    input  logic [4:0] bus_addr,
    input  logic [7:0] bus_data,
    output logic [1:0] image,
    output logic       boot,
    output logic       pending
);

    localparam int CNT_W = $clog2(wb_max(TIMEOUT, ARM_DELAY) + 1);
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ARM_LOAD = CNT_W'(ARM_DELAY - 1);

    warmboot_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       image_q, image_d;
    logic             boot_q, boot_d;
    logic             pending_q, pending_d;

    logic             magic_wr;
    logic [CNT_W-1:0] cnt_dec;

    assign magic_wr = bus_we && (bus_addr == MAGIC_ADDR);
    assign cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        image_d = image_q;

        unique case (state_q)
            WB_IDLE: begin
                if (magic_wr && bus_data == WB_MAGIC_R) begin
                    state_d = WB_GOT_R;
                    cnt_d   = TO_LOAD;
                end
            end
            WB_GOT_R: begin
                // An accepted write takes priority over the timer expiring.
                if (magic_wr) begin
                    if (bus_data == WB_MAGIC_R) begin
                        cnt_d = TO_LOAD;
                    end else if (bus_data == WB_MAGIC_B) begin
                        state_d = WB_GOT_B;
                        cnt_d   = TO_LOAD;
                    end else begin
                        state_d = WB_IDLE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == '0) begin
                    state_d = WB_IDLE;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            WB_GOT_B: begin
                if (magic_wr) begin
                    if (bus_data[7:2] == 6'd0) begin
                        state_d = WB_ARM;
                        image_d = bus_data[1:0];
                        cnt_d   = ARM_LOAD;
                    end else if (bus_data == WB_MAGIC_R) begin
                        state_d = WB_GOT_R;
                        cnt_d   = TO_LOAD;
                    end else begin
                        state_d = WB_IDLE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == '0) begin
                    state_d = WB_IDLE;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            WB_ARM: begin
                if (cnt_q == '0) begin
                    state_d = WB_BOOT;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            WB_BOOT: begin
                state_d = WB_BOOT;
            end
            default: begin
                state_d = WB_IDLE;
                cnt_d   = '0;
                image_d = 2'b00;
            end
        endcase

        // Losing enable aborts everything short of an issued boot.
        if (!enable && state_q != WB_BOOT) begin
            state_d = WB_IDLE;
            cnt_d   = '0;
            image_d = 2'b00;
        end

        boot_d    = (state_d == WB_BOOT);
        pending_d = (state_d == WB_ARM) || (state_d == WB_BOOT);
    end

    always_ff @(posedge clk_24) begin
        if (!rst_24_n) begin
            state_q   <= WB_IDLE;
            cnt_q     <= '0;
            image_q   <= 2'b00;
            boot_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            image_q   <= image_d;
            boot_q    <= boot_d;
            pending_q <= pending_d;
        end
    end

    assign image   = image_q;
    assign boot    = boot_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Scoreboard bench: stimulus queues cycle-tagged expected outputs, a negedge
// monitor pops and compares them when their cycle comes up.
module tb_warmboot_ctrl;

    localparam logic [4:0] MAGIC   = 5'h1F;
    localparam int         TO      = 20;
    localparam int         AD      = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       bus_we;
    logic [4:0] bus_addr;
    logic [7:0] bus_data;
    logic [1:0] image;
    logic       boot;
    logic       pending;

    warmboot_ctrl #(
        .MAGIC_ADDR(MAGIC),
        .TIMEOUT   (TO),
        .ARM_DELAY (AD)
    ) dut (
        .clk_24  (clk),
        .rst_24_n(rst_n),
        .enable  (enable),
        .bus_we  (bus_we),
        .bus_addr(bus_addr),
        .bus_data(bus_data),
        .image   (image),
        .boot    (boot),
        .pending (pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         at;
        logic [1:0] img;
        logic       bt;
        logic       pd;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    tests = 0;
    int    fails = 0;

    // Monitor: compares every expectation due in the current cycle.
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            tests++;
            if (e.at < cyc) begin
                fails++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", nm, e.at, cyc);
            end else if (image !== e.img || boot !== e.bt || pending !== e.pd) begin
                fails++;
                $display("FAIL %s @%0d: got image=%0d boot=%b pending=%b, want image=%0d boot=%b pending=%b",
                         nm, cyc, image, boot, pending, e.img, e.bt, e.pd);
            end else begin
                $display("[TB] ok %s @%0d image=%0d boot=%b pending=%b", nm, cyc, image, boot, pending);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int at, input logic [1:0] img, input logic bt,
                             input logic pd, input string nm);
        exp_t e;
        e.at  = at;
        e.img = img;
        e.bt  = bt;
        e.pd  = pd;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Drives one write during the current cycle; returns that cycle number.
    task automatic wr(input logic [4:0] a, input logic [7:0] d, output int wcyc);
        bus_we   = 1'b1;
        bus_addr = a;
        bus_data = d;
        wcyc     = cyc;
        tick();
        bus_we   = 1'b0;
        bus_addr = 5'h00;
        bus_data = 8'h00;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations still pending after %0d cycles", exp_q.size(), n);
            exp_q.delete();
            name_q.delete();
        end
        tick();
    endtask

    task automatic pulse_reset(input string nm);
        rst_n = 1'b0;
        expect_at(cyc + 1, 2'd0, 1'b0, 1'b0, nm);
        tick();
        rst_n = 1'b1;
        drain();
    endtask

    task automatic expect_boot(input int w, input logic [1:0] img, input string nm);
        expect_at(w + 1,      img, 1'b0, 1'b1, {nm, "_arm_entry"});
        expect_at(w + AD,     img, 1'b0, 1'b1, {nm, "_pre_boot"});
        expect_at(w + AD + 1, img, 1'b1, 1'b1, {nm, "_boot_edge"});
        expect_at(w + AD + 6, img, 1'b1, 1'b1, {nm, "_boot_held"});
    endtask

    task automatic expect_idle(input int w, input string nm);
        expect_at(w + 1,      2'd0, 1'b0, 1'b0, {nm, "_idle"});
        expect_at(w + AD + 3, 2'd0, 1'b0, 1'b0, {nm, "_no_boot"});
    endtask

    initial begin
        int w, w2;
        rst_n    = 1'b0;
        enable   = 1'b1;
        bus_we   = 1'b0;
        bus_addr = 5'h00;
        bus_data = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        expect_at(cyc, 2'd0, 1'b0, 1'b0, "reset_state");
        drain();

        // Basic sequence, image 2; then enable drop in BOOT must not disturb it.
        wr(MAGIC, 8'h52, w);
        wr(MAGIC, 8'h42, w);
        wr(MAGIC, 8'h02, w);
        expect_boot(w, 2'd2, "seq_img2");
        drain();
        enable = 1'b0;
        expect_at(cyc + 1, 2'd2, 1'b1, 1'b1, "boot_ignores_enable");
        tick();
        enable = 1'b1;
        drain();
        pulse_reset("reset_in_boot");

        // Interleaved write to another address is ignored.
        wr(MAGIC, 8'h52, w);
        wr(5'h04, 8'h42, w);
        wr(MAGIC, 8'h42, w);
        wr(MAGIC, 8'h03, w);
        expect_boot(w, 2'd3, "interleave_img3");
        drain();
        pulse_reset("reset_after_img3");

        // Gap of TIMEOUT+1 cycles after 'B': sequence times out.
        wr(MAGIC, 8'h52, w);
        wr(MAGIC, 8'h42, w2);
        repeat (TO + 1) tick();
        wr(MAGIC, 8'h01, w);
        expect_idle(w, "timeout");
        drain();

        // Write on the exact cycle the timer hits zero still advances.
        wr(MAGIC, 8'h52, w);
        wr(MAGIC, 8'h42, w2);
        repeat (TO) tick();
        wr(MAGIC, 8'h01, w);
        expect_boot(w, 2'd1, "timer_zero_write");
        drain();
        pulse_reset("reset_after_img1");

        // Bad image byte aborts; then restart via repeated 'R'.
        wr(MAGIC, 8'h52, w);
        wr(MAGIC, 8'h42, w);
        wr(MAGIC, 8'h05, w);
        expect_idle(w, "bad_image");
        drain();
        wr(MAGIC, 8'h52, w);
        wr(MAGIC, 8'h52, w);
        wr(MAGIC, 8'h42, w);
        wr(MAGIC, 8'h00, w);
        expect_boot(w, 2'd0, "restart_img0");
        drain();
        pulse_reset("reset_after_img0");

        // Enable drop while in ARM aborts the request.
        wr(MAGIC, 8'h52, w);
        wr(MAGIC, 8'h42, w);
        wr(MAGIC, 8'h01, w);
        expect_at(w + 1, 2'd1, 1'b0, 1'b1, "arm_before_abort");
        tick();
        tick();
        enable = 1'b0;
        w = cyc;
        tick();
        enable = 1'b1;
        expect_idle(w, "arm_abort");
        drain();

        // Abort and image write in the same cycle: abort wins.
        wr(MAGIC, 8'h52, w);
        wr(MAGIC, 8'h42, w);
        enable = 1'b0;
        wr(MAGIC, 8'h02, w);
        enable = 1'b1;
        expect_idle(w, "abort_beats_write");
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/warmboot_ctrl.md
# warmboot_ctrl

Upstream feeder of the SB_WARMBOOT primitive in `ice40_init`: watches SID register writes for a magic unlock sequence on an unmapped register and, on completion, drives `image` and then `boot` so the FPGA reconfigures into the selected bitstream. It runs in the 24 MHz domain alongside the SID bus interface. It turns an untimed software command into a glitch-free, image-stable boot request.

## Interface
- `MAGIC_ADDR`, default 5'h1F: register address used for the unlock sequence.
- `TIMEOUT`, default 24_000: max cycles between consecutive sequence writes (1 ms at 24 MHz).
- `ARM_DELAY`, default 240: cycles between image latch and `boot` assertion.
- `clk_24  in  1  24 MHz system clock (from ice40_init).`
- `rst_24_n  in  1  reset; synchronous and active-low; integration drives it from !rst_24.`
- `enable  in  1  1 = sequence detection allowed; 0 = sequence aborted, no boot.`
- `bus_we  in  1  single-cycle register write strobe.`
- `bus_addr  in  5  register address, valid with bus_we.`
- `bus_data  in  8  write data, valid with bus_we.`
- `image  out  2  image select to SB_WARMBOOT S1/S0.`
- `boot  out  1  boot request to SB_WARMBOOT BOOT; sticky once set.`
- `pending  out  1  1 while in ARM or BOOT.`

## Operation
- Sequence: three writes to `MAGIC_ADDR`: 8'h52 ('R'), 8'h42 ('B'), then image byte 8'h00..8'h03. Writes to other addresses are ignored (do not advance, do not abort).
- States: IDLE, GOT_R, GOT_B, ARM, BOOT.
- IDLE: magic write of 8'h52 -> GOT_R; anything else stays.
- GOT_R: magic write 8'h42 -> GOT_B; magic 8'h52 -> GOT_R (restart, timer reload); other magic data -> IDLE.
- GOT_B: magic write with data[7:2]==0 -> latch `image`<=data[1:0], -> ARM; magic 8'h52 -> GOT_R; other -> IDLE.
- ARM: count ARM_DELAY cycles, ignore bus; at terminal count -> BOOT.
- BOOT: `boot`=1, held until reset; bus ignored; `image` frozen.
- Timeout: in GOT_R/GOT_B, timer loaded with TIMEOUT on entry and on each accepted write; reaching 0 -> IDLE.
- `enable`=0 in IDLE/GOT_R/GOT_B/ARM -> IDLE next cycle, `image` cleared to 0. No effect in BOOT.
- Counters: one shared down-counter, width $clog2(max(TIMEOUT,ARM_DELAY)+1); no wrap (saturate at 0).

## Timing
- Reset values: `image`=2'b00, `boot`=0, `pending`=0, state IDLE, counter 0.
- Reset is sampled on `clk_24` only; asserting mid-sequence or in ARM/BOOT returns everything to reset values next edge.
- All outputs registered; state advance one cycle after the qualifying `bus_we`.
- `image` valid the cycle ARM is entered; `boot` rises exactly ARM_DELAY+1 cycles after the image-write `bus_we` cycle; `image` never changes while `boot`=1.
- `pending` rises with entry to ARM.
- Simultaneous accepted write and timer reaching 0: write wins.
- Simultaneous `enable`=0 and write: abort wins.
- `bus_we` high on consecutive cycles is legal; each cycle is a separate write.

## Structure
- Shared package `redip_pkg`: state enum `warmboot_state_t`, magic byte constants `WB_MAGIC_R`, `WB_MAGIC_B`.
- Single module, no sub-modules; counter inline.
- Instantiated at top level; `boot`/`image` wired directly to `ice40_init` ports.

## Test plan
- After reset, magic writes 52,42,02 with `enable`=1 -> `image`=2 on ARM entry, `boot`=1 exactly ARM_DELAY+1 cycles after third write, stays 1.
- Writes 52, (addr 5'h04 data 42), 42, 03 -> interleaved write ignored; `image`=3, `boot`=1.
- Writes 52, 42, then gap TIMEOUT+1 cycles, then 01 -> back to IDLE, `boot` stays 0, `image`=0.
- Writes 52, 42, 05 -> IDLE, no boot; then 52, 52, 42, 00 -> `boot`=1, `image`=0.
- In ARM drop `enable` for one cycle -> IDLE, `pending`=0, `image`=0, no boot; likewise `rst_24_n`=0 in BOOT -> all outputs 0 next edge.
- Accepted write on the same cycle the timer reaches 0 -> sequence advances (no timeout).
